mmio_timer_tx: RTL and testbench

Memory-mapped peripheral responder on the processor's data-memory bus, beside the main memory. It watches the same Address/wr/write-data lines the multicycle datapath drives, and claims a 256-byte address window. Inside the window it holds a free-running timer with compare/interrupt and a 4-entry byte transmit FIFO drained by an external valid/ready consumer. Read data is returned one cycle after the address, the same latency as main memory, so the top level selects between memory and this block using the registered `Hit` flag.

---
 rtl/mmio_timer_tx_if.sv | 23 ++
 rtl/mmio_timer_tx.sv | 163 ++++++++++++++++
 tb/tb_mmio_timer_tx.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_timer_tx_if.sv
// Bus and transmit-stream signals of the mmio_timer_tx peripheral.
// The master side is the processor datapath plus the byte consumer;
// the slave side is the peripheral itself.
interface mmio_timer_tx_if;
    logic [31:0] Address;
    logic        wr;
    logic [31:0] Datain;
    logic [31:0] Dataout;
    logic        Hit;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output Address, wr, Datain, tx_ready,
        input  Dataout, Hit, tx_data, tx_valid
    );

    modport slave (
        input  Address, wr, Datain, tx_ready,
        output Dataout, Hit, tx_data, tx_valid
    );
endinterface

// File: rtl/mmio_timer_tx.sv
// Memory-mapped timer and byte transmit FIFO sitting beside main memory.
// Claims a 256-byte window; read data and Hit are registered so they line
// up with the one-cycle latency of the main memory.
module mmio_timer_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FF00,
    parameter int          FIFO_DEPTH = 4  // power of two, 2..8
) (
    input  logic           clock,
    input  logic           reset_l,
    mmio_timer_tx_if.slave bus,
    output logic           irq
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [5:0] OFF_TXDATA  = 6'h00;
    localparam logic [5:0] OFF_STATUS  = 6'h01;
    localparam logic [5:0] OFF_TIMER   = 6'h02;
    localparam logic [5:0] OFF_COMPARE = 6'h03;
    localparam logic [5:0] OFF_CTRL    = 6'h04;

    // Address decode
    logic       sel;
    logic [5:0] offset;
    logic       wr_en;
    logic       rd_en;
    logic       wr_txdata;
    logic       wr_status;
    logic       wr_timer;
    logic       wr_compare;
    logic       wr_ctrl;

    assign sel        = (bus.Address[31:8] == BASE_ADDR[31:8]);
    assign offset     = bus.Address[7:2];
    assign wr_en      = sel & bus.wr;
    assign rd_en      = sel & ~bus.wr;
    assign wr_txdata  = wr_en && (offset == OFF_TXDATA);
    assign wr_status  = wr_en && (offset == OFF_STATUS);
    assign wr_timer   = wr_en && (offset == OFF_TIMER);
    assign wr_compare = wr_en && (offset == OFF_COMPARE);
    assign wr_ctrl    = wr_en && (offset == OFF_CTRL);

    // Byte-select bits are not part of the register decode.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, bus.Address[1:0]};

    // Architectural registers
    logic [31:0] timer_q;
    logic [31:0] compare_q;
    logic [2:0]  ctrl_q;      // [0] TEN, [1] IEN, [2] ARL
    logic        match_q;
    logic        ovf_q;

    // FIFO state
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [7:0]       last_head;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             push;
    logic             overflow;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign pop        = ~fifo_empty & bus.tx_ready;
    // A full FIFO can still accept a byte when the head leaves at the same edge.
    assign push       = wr_txdata & (~fifo_full | pop);
    assign overflow   = wr_txdata & fifo_full & ~pop;

    assign bus.tx_valid = ~fifo_empty;
    // When empty, keep showing the byte that was last at the head.
    assign bus.tx_data  = fifo_empty ? last_head : mem[rd_ptr];

    // Timer match only counts while the timer is running.
    logic timer_match;
    assign timer_match = ctrl_q[0] & (timer_q == compare_q);

    assign irq = match_q & ctrl_q[1];

    // Timer: bus write beats reload, reload beats increment.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            timer_q <= '0;
        end else if (wr_timer) begin
            timer_q <= bus.Datain;
        end else if (ctrl_q[0]) begin
            timer_q <= (timer_match & ctrl_q[2]) ? '0 : timer_q + 32'd1;
        end
    end

    // Compare and control registers, sticky MATCH/OVF flags (set wins over clear).
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            compare_q <= 32'hFFFF_FFFF;
            ctrl_q    <= '0;
            match_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (wr_compare) compare_q <= bus.Datain;
            if (wr_ctrl)    ctrl_q    <= bus.Datain[2:0];
            if (timer_match)                        match_q <= 1'b1;
            else if (wr_status && bus.Datain[8])    match_q <= 1'b0;
            if (overflow)                           ovf_q   <= 1'b1;
            else if (wr_status && bus.Datain[9])    ovf_q   <= 1'b0;
        end
    end

    // FIFO storage.
    // NOTE: the byte array is not reset; a slot is only read after a push has written it.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= bus.Datain[7:0];
    end

    // FIFO pointers, occupancy and the held head byte; reset empties the FIFO at once.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            last_head <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                last_head <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Register read mux.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    logic [31:0] rd_data;
    always_comb begin
        rd_data = '0;
        case (offset)
            OFF_STATUS:  rd_data = {22'd0, ovf_q, match_q, 2'b00, 4'(count), fifo_full, fifo_empty};
            OFF_TIMER:   rd_data = timer_q;
            OFF_COMPARE: rd_data = compare_q;
            OFF_CTRL:    rd_data = {29'd0, ctrl_q};
            default:     rd_data = '0;
        endcase
    end

    // Registered read response, one cycle after the address like main memory.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            bus.Dataout <= '0;
            bus.Hit     <= 1'b0;
        end else begin
            bus.Dataout <= rd_en ? rd_data : '0;
            bus.Hit     <= rd_en;
        end
    end
endmodule

// File: tb/tb_mmio_timer_tx.sv
// Self-checking bench for mmio_timer_tx. Read responses and transmitted
// bytes are checked against scoreboard queues filled when stimulus is driven.
module tb_mmio_timer_tx;
    localparam logic [31:0] A_TXDATA  = 32'hFFFF_FF00;
    localparam logic [31:0] A_STATUS  = 32'hFFFF_FF04;
    localparam logic [31:0] A_TIMER   = 32'hFFFF_FF08;
    localparam logic [31:0] A_COMPARE = 32'hFFFF_FF0C;
    localparam logic [31:0] A_CTRL    = 32'hFFFF_FF10;

    typedef struct packed {
        logic        hit;
        logic [31:0] data;
        logic [31:0] addr;
    } rd_exp_t;

    logic clock = 1'b0;
    logic reset_l;
    logic irq;
    int   tests = 0;
    int   fails = 0;

    rd_exp_t    rd_q[$];
    logic [7:0] tx_q[$];

    mmio_timer_tx_if bus ();

    mmio_timer_tx dut (
        .clock  (clock),
        .reset_l(reset_l),
        .bus    (bus),
        .irq    (irq)
    );

    always #5 clock = ~clock;

    // Read scoreboard: a read driven before edge N is checked 1 ns after edge N.
    always @(posedge clock) begin
        rd_exp_t e;
        #1;
        if (rd_q.size() > 0) begin
            e = rd_q.pop_front();
            tests++;
            if (bus.Hit !== e.hit || bus.Dataout !== e.data) begin
                fails++;
                $display("FAIL read %h: got Hit=%b Dataout=%h, expected Hit=%b Dataout=%h",
                         e.addr, bus.Hit, bus.Dataout, e.hit, e.data);
            end
        end
    end

    // Transmit scoreboard: a handshake visible at the falling edge completes at the next rising edge.
    always @(negedge clock) begin
        logic [7:0] exp_byte;
        if (reset_l === 1'b1 && bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
            tests++;
            if (tx_q.size() == 0) begin
                fails++;
                $display("FAIL tx_unexpected: got byte %h, expected no handshake", bus.tx_data);
            end else begin
                exp_byte = tx_q.pop_front();
                if (bus.tx_data !== exp_byte) begin
                    fails++;
                    $display("FAIL tx_byte: got %h, expected %h", bus.tx_data, exp_byte);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge clock); #2;
        bus.Address = a; bus.wr = 1'b1; bus.Datain = d;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic hit, input logic [31:0] d);
        @(posedge clock); #2;
        bus.Address = a; bus.wr = 1'b0; bus.Datain = '0;
        rd_q.push_back({hit, d, a});
    endtask

    task automatic bus_idle();
        @(posedge clock); #2;
        bus.Address = '0; bus.wr = 1'b0; bus.Datain = '0;
    endtask

    task automatic do_reset();
        @(posedge clock); #2;
        bus.Address = '0; bus.wr = 1'b0; bus.Datain = '0; bus.tx_ready = 1'b0;
        reset_l = 1'b0;
        repeat (2) @(negedge clock);
        reset_l = 1'b1;
        tx_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (bus.Dataout !== 32'h0) begin fails++; $display("FAIL rst_dataout: got %h, expected 0", bus.Dataout); end
        tests++; if (bus.Hit !== 1'b0)      begin fails++; $display("FAIL rst_hit: got %b, expected 0", bus.Hit); end
        tests++; if (bus.tx_valid !== 1'b0) begin fails++; $display("FAIL rst_tx_valid: got %b, expected 0", bus.tx_valid); end
        tests++; if (bus.tx_data !== 8'h0)  begin fails++; $display("FAIL rst_tx_data: got %h, expected 0", bus.tx_data); end
        tests++; if (irq !== 1'b0)          begin fails++; $display("FAIL rst_irq: got %b, expected 0", irq); end
        bus_read(A_STATUS, 1'b1, 32'h0000_0001);
        bus_read(32'h0000_0004, 1'b0, 32'h0);
        bus_read(A_COMPARE, 1'b1, 32'hFFFF_FFFF);
        bus_read(A_CTRL, 1'b1, 32'h0);
        bus_read(A_TIMER, 1'b1, 32'h0);
        bus_read(A_TXDATA, 1'b1, 32'h0);
        bus_idle();
    endtask

    task automatic test_fifo_overflow();
        do_reset();
        for (int b = 8'h41; b <= 8'h45; b++) begin
            bus_write(A_TXDATA, 32'(b));
            if (b <= 8'h44) tx_q.push_back(8'(b));
        end
        bus_read(A_STATUS, 1'b1, 32'h0000_0212);
        bus_idle();
        tests++; if (bus.tx_valid !== 1'b1) begin fails++; $display("FAIL ovf_valid: got %b, expected 1", bus.tx_valid); end
        tests++; if (bus.tx_data !== 8'h41) begin fails++; $display("FAIL ovf_head: got %h, expected 41", bus.tx_data); end
        bus.tx_ready = 1'b1;
        repeat (4) @(posedge clock);
        #2;
        tests++; if (bus.tx_valid !== 1'b0) begin fails++; $display("FAIL drain_valid: got %b, expected 0", bus.tx_valid); end
        tests++; if (bus.tx_data !== 8'h44) begin fails++; $display("FAIL drain_hold: got %h, expected 44", bus.tx_data); end
        tests++; if (tx_q.size() != 0) begin fails++; $display("FAIL drain_left: got %0d bytes pending, expected 0", tx_q.size()); end
        bus.tx_ready = 1'b0;
        bus_read(A_STATUS, 1'b1, 32'h0000_0201);
        bus_write(A_STATUS, 32'h0000_0200);
        bus_read(A_STATUS, 1'b1, 32'h0000_0001);
        bus_idle();
    endtask

    task automatic test_push_pop_full();
        do_reset();
        for (int b = 8'h61; b <= 8'h64; b++) begin
            bus_write(A_TXDATA, 32'(b));
            tx_q.push_back(8'(b));
        end
        bus_write(A_TXDATA, 32'h55);
        bus.tx_ready = 1'b1;
        tx_q.push_back(8'h55);
        bus_read(A_STATUS, 1'b1, 32'h0000_0012);
        bus.tx_ready = 1'b0;
        bus_idle();
        tests++; if (bus.tx_data !== 8'h62) begin fails++; $display("FAIL pp_head: got %h, expected 62", bus.tx_data); end
        bus.tx_ready = 1'b1;
        repeat (4) @(posedge clock);
        #2;
        tests++; if (bus.tx_valid !== 1'b0) begin fails++; $display("FAIL pp_valid: got %b, expected 0", bus.tx_valid); end
        tests++; if (bus.tx_data !== 8'h55) begin fails++; $display("FAIL pp_last: got %h, expected 55", bus.tx_data); end
        tests++; if (tx_q.size() != 0) begin fails++; $display("FAIL pp_left: got %0d bytes pending, expected 0", tx_q.size()); end
        bus.tx_ready = 1'b0;
    endtask

    task automatic test_timer_match();
        do_reset();
        bus_write(A_COMPARE, 32'd5);
        bus_write(A_CTRL, 32'h7);
        // Auto-reload: timer counts 0..5 then restarts at 0; irq rises after the match edge.
        for (int k = 1; k <= 8; k++) begin
            bus_read(A_TIMER, 1'b1, (k <= 6) ? 32'(k - 1) : 32'(k - 7));
            tests++;
            if (irq !== (k >= 7)) begin
                fails++;
                $display("FAIL arl_irq step %0d: got %b, expected %b", k, irq, (k >= 7));
            end
        end
        bus_write(A_STATUS, 32'h0000_0100);
        bus_idle();
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_clear: got %b, expected 0", irq); end
        // No auto-reload: timer runs through the compare value.
        bus_write(A_CTRL, 32'h0);
        bus_write(A_TIMER, 32'h0);
        bus_write(A_STATUS, 32'h0000_0100);
        bus_write(A_CTRL, 32'h3);
        for (int k = 1; k <= 9; k++) begin
            bus_read(A_TIMER, 1'b1, 32'(k - 1));
            tests++;
            if (irq !== (k >= 7)) begin
                fails++;
                $display("FAIL run_irq step %0d: got %b, expected %b", k, irq, (k >= 7));
            end
        end
        bus_write(A_CTRL, 32'h1);
        bus_idle();
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_ien_off: got %b, expected 0", irq); end
        bus_read(A_STATUS, 1'b1, 32'h0000_0101);
        bus_idle();
    endtask

    task automatic test_wrap();
        do_reset();
        bus_write(A_TIMER, 32'hFFFF_FFFF);
        bus_write(A_CTRL, 32'h1);
        bus_idle();
        bus_read(A_TIMER, 1'b1, 32'h0);
        bus_write(A_TIMER, 32'h10);
        bus_read(A_TIMER, 1'b1, 32'h10);
        bus_read(A_STATUS, 1'b1, 32'h0000_0101);
        bus_idle();
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL wrap_irq: got %b, expected 0", irq); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.tx_ready = 1'b1;
        bus_write(A_TXDATA, 32'h11); tx_q.push_back(8'h11);
        bus_write(A_TXDATA, 32'h22); tx_q.push_back(8'h22);
        bus_write(A_TXDATA, 32'h33); tx_q.push_back(8'h33);
        bus_idle();
        bus_idle();
        tests++; if (bus.tx_valid !== 1'b0) begin fails++; $display("FAIL b2b_valid: got %b, expected 0", bus.tx_valid); end
        tests++; if (tx_q.size() != 0) begin fails++; $display("FAIL b2b_left: got %0d bytes pending, expected 0", tx_q.size()); end
        bus.tx_ready = 1'b0;
        bus_write(32'hFFFF_FF20, 32'hDEAD_BEEF);
        bus_write(32'h0000_0000, 32'h99);
        bus_read(32'hFFFF_FF20, 1'b1, 32'h0);
        bus_read(A_STATUS, 1'b1, 32'h0000_0001);
        bus_idle();
    endtask

    task automatic test_async_reset();
        do_reset();
        bus_write(A_TXDATA, 32'hA1);
        bus_write(A_TXDATA, 32'hA2);
        bus_write(A_TXDATA, 32'hA3);
        bus_write(A_COMPARE, 32'h0);
        bus_write(A_CTRL, 32'h3);
        bus_idle();
        @(posedge clock); #2;
        bus.Address = A_STATUS; bus.wr = 1'b0;
        @(posedge clock); #3;
        tests++; if (irq !== 1'b1)          begin fails++; $display("FAIL pre_irq: got %b, expected 1", irq); end
        tests++; if (bus.Hit !== 1'b1)      begin fails++; $display("FAIL pre_hit: got %b, expected 1", bus.Hit); end
        tests++; if (bus.tx_valid !== 1'b1) begin fails++; $display("FAIL pre_valid: got %b, expected 1", bus.tx_valid); end
        reset_l = 1'b0;
        bus.Address = '0;
        #1;
        tests++; if (bus.Dataout !== 32'h0) begin fails++; $display("FAIL arst_dataout: got %h, expected 0", bus.Dataout); end
        tests++; if (bus.Hit !== 1'b0)      begin fails++; $display("FAIL arst_hit: got %b, expected 0", bus.Hit); end
        tests++; if (bus.tx_valid !== 1'b0) begin fails++; $display("FAIL arst_valid: got %b, expected 0", bus.tx_valid); end
        tests++; if (bus.tx_data !== 8'h0)  begin fails++; $display("FAIL arst_tx_data: got %h, expected 0", bus.tx_data); end
        tests++; if (irq !== 1'b0)          begin fails++; $display("FAIL arst_irq: got %b, expected 0", irq); end
        @(negedge clock);
        @(negedge clock);
        reset_l = 1'b1;
        bus_read(A_STATUS, 1'b1, 32'h0000_0001);
        bus_read(A_CTRL, 1'b1, 32'h0);
        bus_read(A_TIMER, 1'b1, 32'h0);
        bus_idle();
    endtask

    initial begin
        reset_l      = 1'b0;
        bus.Address  = '0;
        bus.wr       = 1'b0;
        bus.Datain   = '0;
        bus.tx_ready = 1'b0;
        test_reset();
        test_fifo_overflow();
        test_push_pop_full();
        test_timer_match();
        test_wrap();
        test_back_to_back();
        test_async_reset();
        repeat (3) @(posedge clock);
        #2;
        tests++;
        if (rd_q.size() != 0) begin
            fails++;
            $display("FAIL read_queue: got %0d reads unchecked, expected 0", rd_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
